// File: rtl/pp_sp_pcie_endpoint_if.sv
// Avalon-ST RX/TX pair plus the repacked payload stream of the PCIe endpoint.
// The slave modport is the endpoint's view; the master modport is the driving side.
interface pp_sp_pcie_endpoint_if #(
    parameter int unsigned DATA_W = 256
);
    logic [DATA_W-1:0] rx_st_data;
    logic              rx_st_valid;
    logic              rx_st_sop;
    logic              rx_st_eop;
    logic [1:0]        rx_st_empty;
    logic              rx_st_err;
    logic              rx_st_ready;

    logic [DATA_W-1:0] tx_st_data;
    logic              tx_st_valid;
    logic              tx_st_sop;
    logic              tx_st_eop;
    logic              tx_st_ready;

    logic              data_valid;
    logic [DATA_W-1:0] data_data;
    logic [4:0]        data_empty;

    modport master (
        output rx_st_data, rx_st_valid, rx_st_sop, rx_st_eop, rx_st_empty, rx_st_err,
        input  rx_st_ready,
        input  tx_st_data, tx_st_valid, tx_st_sop, tx_st_eop,
        output tx_st_ready,
        input  data_valid, data_data, data_empty
    );

    modport slave (
        input  rx_st_data, rx_st_valid, rx_st_sop, rx_st_eop, rx_st_empty, rx_st_err,
        output rx_st_ready,
        output tx_st_data, tx_st_valid, tx_st_sop, tx_st_eop,
        input  tx_st_ready,
        output data_valid, data_data, data_empty
    );
endinterface

// File: rtl/pp_sp_pcie_endpoint.sv
// PCIe RX completion handler: parses CplD TLPs from a 256-bit Avalon-ST stream
// and repacks their payload into 32-byte output beats; the TX port stays idle.
module pp_sp_pcie_endpoint #(
    parameter int unsigned DATA_W = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    pp_sp_pcie_endpoint_if.slave   bus
);
    localparam int unsigned NDW = DATA_W / 32;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_DATA,
        ST_DROP
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              flush_q, flush_d;
    logic [10:0]       rem_q, rem_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       held_q [NDW];
    logic [31:0]       held_d [NDW];
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [4:0]        out_empty_q, out_empty_d;

    logic [31:0]       beat_dw [NDW];
    logic [31:0]       comb_dw [2*NDW];
    logic              accept;
    logic              hdr_beat;
    logic              is_cpld;
    logic [10:0]       hdr_len;
    logic [3:0]        hdr_start;
    logic [3:0]        avail_hdr;

    logic [3:0]        base_cnt;
    logic [3:0]        start;
    logic [3:0]        take;
    logic [10:0]       rem_after;
    logic [4:0]        total;
    logic              pack;
    logic              tlp_end;
    int unsigned       j;

    always_comb begin
        for (int unsigned k = 0; k < NDW; k++) begin
            beat_dw[k] = bus.rx_st_data[32*k +: 32];
        end
    end

    assign accept    = bus.rx_st_valid & ready_q;
    assign hdr_beat  = (state_q == ST_HDR) || bus.rx_st_sop;
    assign is_cpld   = (beat_dw[0][31:24] == 8'h4A);
    assign hdr_len   = (beat_dw[0][9:0] == 10'd0) ? 11'd1024 : {1'b0, beat_dw[0][9:0]};
    // LowerAddr[2] selects whether the 3DW header is followed by a QW-alignment pad DW.
    assign hdr_start = beat_dw[2][2] ? 4'd3 : 4'd4;
    assign avail_hdr = 4'd8 - hdr_start;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        held_d      = held_q;
        ready_d     = 1'b1;
        flush_d     = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_empty_d = out_empty_q;
        base_cnt    = cnt_q;
        start       = '0;
        take        = '0;
        rem_after   = rem_q;
        pack        = 1'b0;
        tlp_end     = 1'b0;
        j           = '0;

        if (flush_q) begin
            pack    = 1'b1;
            tlp_end = 1'b1;
        end else if (accept) begin
            if (hdr_beat) begin
                base_cnt = '0;
                cnt_d    = '0;
                if (is_cpld) begin
                    start     = hdr_start;
                    take      = (hdr_len < 11'(avail_hdr)) ? hdr_len[3:0] : avail_hdr;
                    rem_after = hdr_len - 11'(take);
                    rem_d     = rem_after;
                    pack      = 1'b1;
                    tlp_end   = (rem_after == '0);
                    state_d   = tlp_end ? ST_HDR : ST_DATA;
                end else begin
                    state_d = bus.rx_st_eop ? ST_HDR : ST_DROP;
                end
            end else if (state_q == ST_DATA) begin
                take      = (rem_q < 11'd8) ? rem_q[3:0] : 4'd8;
                rem_after = rem_q - 11'(take);
                rem_d     = rem_after;
                pack      = 1'b1;
                tlp_end   = (rem_after == '0);
                state_d   = tlp_end ? ST_HDR : ST_DATA;
            end else if (bus.rx_st_eop) begin
                state_d = ST_HDR;
            end
        end

        total = 5'(base_cnt) + 5'(take);

        // Held DWs first, then this beat's payload DWs, zero beyond the total.
        for (int unsigned i = 0; i < 2*NDW; i++) begin
            comb_dw[i] = '0;
            if (i < 32'(base_cnt)) begin
                comb_dw[i] = held_q[3'(i)];
            end else if ((i - 32'(base_cnt)) < 32'(take)) begin
                j          = 32'(start) + i - 32'(base_cnt);
                comb_dw[i] = beat_dw[3'(j)];
            end
        end

        if (pack) begin
            if (total >= 5'd8) begin
                out_valid_d = 1'b1;
                out_empty_d = '0;
                for (int unsigned k = 0; k < NDW; k++) begin
                    out_data_d[32*k +: 32] = comb_dw[k];
                    held_d[k]              = comb_dw[4'(k + NDW)];
                end
                cnt_d = 4'(total - 5'd8);
                if (tlp_end && (total > 5'd8)) begin
                    flush_d = 1'b1;
                    ready_d = 1'b0;
                end
            end else if (tlp_end) begin
                if (total != '0) begin
                    out_valid_d = 1'b1;
                    out_empty_d = {3'(5'd8 - total), 2'b00};
                    for (int unsigned k = 0; k < NDW; k++) begin
                        out_data_d[32*k +: 32] = comb_dw[k];
                    end
                end
                cnt_d = '0;
            end else begin
                for (int unsigned k = 0; k < NDW; k++) begin
                    held_d[k] = comb_dw[k];
                end
                cnt_d = total[3:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HDR;
            ready_q     <= 1'b0;
            flush_q     <= 1'b0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_empty_q <= '0;
            for (int unsigned k = 0; k < NDW; k++) begin
                held_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            flush_q     <= flush_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_empty_q <= out_empty_d;
            held_q      <= held_d;
        end
    end

    assign bus.rx_st_ready = ready_q;
    assign bus.data_valid  = out_valid_q;
    assign bus.data_data   = out_data_q;
    assign bus.data_empty  = out_empty_q;
    assign bus.tx_st_data  = '0;
    assign bus.tx_st_valid = 1'b0;
    assign bus.tx_st_sop   = 1'b0;
    assign bus.tx_st_eop   = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{bus.rx_st_empty, bus.rx_st_err, bus.tx_st_ready};
endmodule

// File: tb/tb_pp_sp_pcie_endpoint.sv
// Directed bench for the PCIe CplD repacker: drives TLP beats and checks output beats.
module tb_pp_sp_pcie_endpoint;
    logic clock;
    logic reset;
    int   cyc;
    int   acc_cyc;
    int   tests_run;
    int   tests_failed;

    logic [255:0] oq_data [$];
    logic [4:0]   oq_empty [$];
    int           oq_cyc [$];

    pp_sp_pcie_endpoint_if #(.DATA_W(256)) bus ();

    pp_sp_pcie_endpoint #(.DATA_W(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.data_valid === 1'b1) begin
            oq_data.push_back(bus.data_data);
            oq_empty.push_back(bus.data_empty);
            oq_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] pat(input int k);
        return {16'(2*k + 1), 16'(2*k)};
    endfunction

    function automatic logic [255:0] junk();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
        return b;
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [7:0] fmt, input logic [9:0] lenf, input bit la2);
        logic [255:0] b;
        b = junk();
        b[31:0]  = {fmt, 14'h0, lenf};
        b[63:32] = 32'h0100_0004;
        b[95:64] = {25'h0, la2 ? 7'h14 : 7'h10};
        return b;
    endfunction

    function automatic logic [255:0] exp_beat(input int k0, input int n);
        logic [255:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[32*i +: 32] = pat(k0 + i);
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_q();
        oq_data.delete();
        oq_empty.delete();
        oq_cyc.delete();
    endtask

    task automatic send_beat(input logic [255:0] d, input logic sop, input logic eop);
        int n;
        bus.rx_st_data  = d;
        bus.rx_st_sop   = sop;
        bus.rx_st_eop   = eop;
        bus.rx_st_valid = 1'b1;
        n = 0;
        while (bus.rx_st_ready !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (bus.rx_st_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout: rx_st_ready=%b, required 1 within 20 cycles", bus.rx_st_ready);
        end
        @(posedge clock);
        #1;
        acc_cyc         = cyc;
        bus.rx_st_valid = 1'b0;
        bus.rx_st_sop   = 1'b0;
        bus.rx_st_eop   = 1'b0;
    endtask

    task automatic send_cpld(input logic [9:0] lenf, input int ndw, input int k0,
                             input bit la2, input bit sop, input bit eop);
        logic [255:0] b;
        int  pos;
        bit  first;
        b     = mk_hdr(8'h4A, lenf, la2);
        pos   = la2 ? 3 : 4;
        first = 1'b1;
        for (int k = 0; k < ndw; k++) begin
            if (pos == 8) begin
                send_beat(b, first ? sop : 1'b0, 1'b0);
                first = 1'b0;
                b     = junk();
                pos   = 0;
            end
            b[32*pos +: 32] = pat(k0 + k);
            pos++;
        end
        send_beat(b, first ? sop : 1'b0, eop);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        tests_run++;
        if (bus.rx_st_ready !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_empty !== 5'd0 ||
            bus.data_data !== 256'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b valid=%b empty=%0d data=%h, required 0/0/0/0",
                     bus.rx_st_ready, bus.data_valid, bus.data_empty, bus.data_data);
        end
        tests_run++;
        if (bus.tx_st_valid !== 1'b0 || bus.tx_st_sop !== 1'b0 || bus.tx_st_eop !== 1'b0 ||
            bus.tx_st_data !== 256'd0) begin
            tests_failed++;
            $display("FAIL reset_tx: tx valid=%b sop=%b eop=%b, required all 0", bus.tx_st_valid,
                     bus.tx_st_sop, bus.tx_st_eop);
        end
        reset = 1'b0;
        idle(1);
        tests_run++;
        if (bus.rx_st_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: rx_st_ready=%b, required 1", bus.rx_st_ready);
        end
    endtask

    task automatic test_len1();
        clear_q();
        send_cpld(10'd1, 1, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 1) begin
            tests_failed++;
            $display("FAIL len1_count: beats=%0d, required 1", oq_data.size());
        end else begin
            tests_run++;
            if (oq_data[0] !== 256'h0001_0000 || oq_empty[0] !== 5'd28) begin
                tests_failed++;
                $display("FAIL len1_beat: data=%h empty=%0d, required %h empty 28",
                         oq_data[0], oq_empty[0], 256'h0001_0000);
            end
            tests_run++;
            if (oq_cyc[0] !== acc_cyc) begin
                tests_failed++;
                $display("FAIL len1_latency: out cycle=%0d, required %0d", oq_cyc[0], acc_cyc);
            end
        end
    endtask

    task automatic test_len2();
        clear_q();
        send_cpld(10'd2, 2, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 1 || oq_data[0] !== 256'h0003_0002_0001_0000 || oq_empty[0] !== 5'd24) begin
            tests_failed++;
            $display("FAIL len2_beat: beats=%0d data=%h empty=%0d, required 1 beat %h empty 24",
                     oq_data.size(), oq_data[0], oq_empty[0], 256'h0003_0002_0001_0000);
        end
    endtask

    task automatic test_len8();
        clear_q();
        send_cpld(10'd8, 8, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 1 || oq_data[0] !== exp_beat(0, 8) || oq_empty[0] !== 5'd0) begin
            tests_failed++;
            $display("FAIL len8_beat: beats=%0d data=%h empty=%0d, required 1 beat %h empty 0",
                     oq_data.size(), oq_data[0], oq_empty[0], exp_beat(0, 8));
        end
    endtask

    task automatic test_len16();
        clear_q();
        send_cpld(10'd16, 16, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL len16_count: beats=%0d, required 2", oq_data.size());
        end
        for (int i = 0; i < 2 && i < oq_data.size(); i++) begin
            tests_run++;
            if (oq_data[i] !== exp_beat(8*i, 8) || oq_empty[i] !== 5'd0) begin
                tests_failed++;
                $display("FAIL len16_beat%0d: data=%h empty=%0d, required %h empty 0",
                         i, oq_data[i], oq_empty[i], exp_beat(8*i, 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_cpld(10'd16, 16, 0, 1'b0, 1'b1, 1'b0);
        send_cpld(10'd2, 2, 16, 1'b0, 1'b0, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count: beats=%0d, required 3", oq_data.size());
        end else begin
            tests_run++;
            if (oq_data[0] !== exp_beat(0, 8) || oq_data[1] !== exp_beat(8, 8) ||
                oq_empty[0] !== 5'd0 || oq_empty[1] !== 5'd0) begin
                tests_failed++;
                $display("FAIL b2b_full: data0=%h data1=%h, required %h %h",
                         oq_data[0], oq_data[1], exp_beat(0, 8), exp_beat(8, 8));
            end
            tests_run++;
            if (oq_data[2] !== 256'h0023_0022_0021_0020 || oq_empty[2] !== 5'd24) begin
                tests_failed++;
                $display("FAIL b2b_tail: data=%h empty=%0d, required %h empty 24",
                         oq_data[2], oq_empty[2], 256'h0023_0022_0021_0020);
            end
        end
    endtask

    task automatic test_len32();
        clear_q();
        send_cpld(10'd32, 32, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 4) begin
            tests_failed++;
            $display("FAIL len32_count: beats=%0d, required 4", oq_data.size());
        end
        for (int i = 0; i < 4 && i < oq_data.size(); i++) begin
            tests_run++;
            if (oq_data[i] !== exp_beat(8*i, 8) || oq_empty[i] !== 5'd0) begin
                tests_failed++;
                $display("FAIL len32_beat%0d: data=%h empty=%0d, required %h empty 0",
                         i, oq_data[i], oq_empty[i], exp_beat(8*i, 8));
            end
        end
    endtask

    task automatic test_flush();
        int acc;
        clear_q();
        send_cpld(10'd12, 12, 70, 1'b1, 1'b1, 1'b1);
        acc = acc_cyc;
        tests_run++;
        if (bus.rx_st_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stall: rx_st_ready=%b, required 0", bus.rx_st_ready);
        end
        idle(1);
        tests_run++;
        if (bus.rx_st_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_resume: rx_st_ready=%b, required 1", bus.rx_st_ready);
        end
        idle(3);
        tests_run++;
        if (oq_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL flush_count: beats=%0d, required 2", oq_data.size());
        end else begin
            tests_run++;
            if (oq_data[0] !== exp_beat(70, 8) || oq_empty[0] !== 5'd0 || oq_cyc[0] !== acc) begin
                tests_failed++;
                $display("FAIL flush_first: data=%h empty=%0d cyc=%0d, required %h empty 0 cyc %0d",
                         oq_data[0], oq_empty[0], oq_cyc[0], exp_beat(70, 8), acc);
            end
            tests_run++;
            if (oq_data[1] !== exp_beat(78, 4) || oq_empty[1] !== 5'd16 || oq_cyc[1] !== acc + 1) begin
                tests_failed++;
                $display("FAIL flush_second: data=%h empty=%0d cyc=%0d, required %h empty 16 cyc %0d",
                         oq_data[1], oq_empty[1], oq_cyc[1], exp_beat(78, 4), acc + 1);
            end
        end
    endtask

    task automatic test_len1024();
        int bad;
        clear_q();
        send_cpld(10'd0, 1024, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 128) begin
            tests_failed++;
            $display("FAIL len1024_count: beats=%0d, required 128", oq_data.size());
        end
        bad = 0;
        for (int i = 0; i < oq_data.size(); i++) begin
            if (oq_data[i] !== exp_beat(8*i, 8) || oq_empty[i] !== 5'd0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL len1024_data: bad beats=%0d, required 0", bad);
        end
    endtask

    task automatic test_sop_abort();
        logic [255:0] b;
        clear_q();
        b = mk_hdr(8'h4A, 10'd16, 1'b0);
        for (int i = 0; i < 4; i++) b[32*(4+i) +: 32] = pat(i);
        send_beat(b, 1'b1, 1'b0);
        send_cpld(10'd1, 1, 40, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 1 || oq_data[0] !== exp_beat(40, 1) || oq_empty[0] !== 5'd28) begin
            tests_failed++;
            $display("FAIL sop_abort: beats=%0d data=%h empty=%0d, required 1 beat %h empty 28",
                     oq_data.size(), oq_data[0], oq_empty[0], exp_beat(40, 1));
        end
    endtask

    task automatic test_drop();
        logic [255:0] b;
        clear_q();
        send_beat(mk_hdr(8'h40, 10'd12, 1'b0), 1'b1, 1'b0);
        b = mk_hdr(8'h4A, 10'd1, 1'b0);
        send_beat(b, 1'b0, 1'b1);
        idle(3);
        tests_run++;
        if (oq_data.size() !== 0) begin
            tests_failed++;
            $display("FAIL drop_silent: beats=%0d, required 0", oq_data.size());
        end
        send_cpld(10'd1, 1, 60, 1'b0, 1'b1, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 1 || oq_data[0] !== exp_beat(60, 1) || oq_empty[0] !== 5'd28) begin
            tests_failed++;
            $display("FAIL drop_then_cpld: beats=%0d data=%h, required 1 beat %h",
                     oq_data.size(), oq_data[0], exp_beat(60, 1));
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] b;
        clear_q();
        b = mk_hdr(8'h4A, 10'd16, 1'b0);
        for (int i = 0; i < 4; i++) b[32*(4+i) +: 32] = pat(i);
        send_beat(b, 1'b1, 1'b0);
        reset = 1'b1;
        idle(2);
        tests_run++;
        if (bus.rx_st_ready !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_data !== 256'd0 ||
            bus.data_empty !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: ready=%b valid=%b empty=%0d data=%h, required all 0",
                     bus.rx_st_ready, bus.data_valid, bus.data_empty, bus.data_data);
        end
        reset = 1'b0;
        send_cpld(10'd2, 2, 50, 1'b0, 1'b0, 1'b1);
        idle(4);
        tests_run++;
        if (oq_data.size() !== 1 || oq_data[0] !== exp_beat(50, 2) || oq_empty[0] !== 5'd24) begin
            tests_failed++;
            $display("FAIL reset_mid_cpld: beats=%0d data=%h empty=%0d, required 1 beat %h empty 24",
                     oq_data.size(), oq_data[0], oq_empty[0], exp_beat(50, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc             = 0;
        acc_cyc         = 0;
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b1;
        bus.rx_st_data  = '0;
        bus.rx_st_valid = 1'b0;
        bus.rx_st_sop   = 1'b0;
        bus.rx_st_eop   = 1'b0;
        bus.rx_st_empty = 2'd2;
        bus.rx_st_err   = 1'b0;
        bus.tx_st_ready = 1'b1;
        #1;
        test_reset();
        test_len1();
        test_len2();
        test_len8();
        test_len16();
        test_back_to_back();
        test_len32();
        test_flush();
        test_len1024();
        test_sop_abort();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
